// File: rtl/cordic_sincos_iter_if.sv
// Handshake and data bundle for cordic_sincos_iter: start request and angle in,
// busy/done/err status and the sine/cosine pair out.
interface cordic_sincos_iter_if #(
  parameter int WIDTH = 32
) ();
  logic                    enable;
  logic signed [WIDTH-1:0] z_in;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;

  modport master (output enable, z_in, input busy, done, err, cos_out, sin_out);
  modport slave  (input enable, z_in, output busy, done, err, cos_out, sin_out);
endinterface

// File: rtl/cordic_sincos_iter.sv
// Iterative CORDIC rotation core: one micro-rotation per clock, sine and cosine together.
// Define CORDIC_QUAD_EN to fold angles beyond +/-pi/2 and accept the full [-pi, pi] range.
module cordic_sincos_iter #(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 16,
  parameter int ITERATIONS = 16
) (
  input logic                  clk,
  input logic                  rst,
  cordic_sincos_iter_if.slave  bus
);

  localparam int DW = WIDTH + 2;
  localparam int SH = 30 - FRAC;

  typedef logic signed [DW-1:0] dw_t;
  typedef enum logic [1:0] {IDLE, ROTATE, FINISH} state_t;

  // Q2.30 constant rescaled to FRAC bits with round-half-up.
  function automatic logic [63:0] rnd(input logic [63:0] v);
    return (v + ((64'd1 << SH) >> 1)) >> SH;
  endfunction

  function automatic dw_t atan_tab(input logic [4:0] i);
    logic [63:0] raw;
    case (i)
      5'd0:    raw = 64'h3243F6A9;
      5'd1:    raw = 64'h1DAC6705;
      5'd2:    raw = 64'h0FADBAFD;
      5'd3:    raw = 64'h07F56EA7;
      5'd4:    raw = 64'h03FEAB77;
      5'd5:    raw = 64'h01FFD55C;
      5'd6:    raw = 64'h00FFFAAB;
      5'd7:    raw = 64'h007FFF55;
      5'd8:    raw = 64'h003FFFEB;
      5'd9:    raw = 64'h001FFFFD;
      // atan(2^-i) rounds to exactly 2^-i in Q2.30 from here on
      default: raw = (i < 5'd30) ? (64'd1 << (5'd30 - i)) : 64'd0;
    endcase
    return dw_t'(rnd(raw));
  endfunction

  localparam dw_t K_C   = dw_t'(rnd(64'h26DD3B6A));
  localparam dw_t PI_C  = dw_t'(rnd(64'hC90FDAA2));
  localparam dw_t HPI_C = dw_t'(rnd(64'h6487ED51));

  state_t                  state_q, state_d;
  dw_t                     x_q, x_d, y_q, y_d, z_q, z_d;
  logic [4:0]              iter_q, iter_d;
  logic                    neg_q, neg_d;
  logic                    bad_q, bad_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic signed [WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;

  dw_t  zin, zf, xs, ys, atan_i, xo, yo;
  logic negf, range_bad;

  // Angle folding and range check on the incoming angle.
  always_comb begin
    zin  = {{2{bus.z_in[WIDTH-1]}}, bus.z_in};
    zf   = zin;
    negf = 1'b0;
`ifdef CORDIC_QUAD_EN
    if (zin > HPI_C) begin
      zf   = zin - PI_C;
      negf = 1'b1;
    end else if (zin < -HPI_C) begin
      zf   = zin + PI_C;
      negf = 1'b1;
    end
    range_bad = (zin > PI_C) || (zin < -PI_C);
`else
    range_bad = (zin > HPI_C) || (zin < -HPI_C);
`endif
  end

  always_comb begin
    xs     = x_q >>> iter_q;
    ys     = y_q >>> iter_q;
    atan_i = atan_tab(iter_q);
    xo     = neg_q ? -x_q : x_q;
    yo     = neg_q ? -y_q : y_q;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    neg_d   = neg_q;
    bad_d   = bad_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          x_d     = K_C;
          y_d     = '0;
          z_d     = zf;
          iter_d  = '0;
          neg_d   = negf;
          bad_d   = range_bad;
          busy_d  = 1'b1;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        if (!z_q[DW-1]) begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_i;
        end
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'(ITERATIONS - 1)) state_d = FINISH;
      end
      FINISH: begin
        cos_d   = bad_q ? '0 : xo[WIDTH-1:0];
        sin_d   = bad_q ? '0 : yo[WIDTH-1:0];
        err_d   = bad_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      neg_q   <= 1'b0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      neg_q   <= neg_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.cos_out = cos_q;
  assign bus.sin_out = sin_q;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Scoreboarded bench for cordic_sincos_iter (Q16.16, 16 iterations) against a real-valued trig model.
module tb_cordic_sincos_iter;
  localparam int    W     = 32;
  localparam int    TOL   = 16;
  localparam real   PI_R  = 3.14159265358979323846;
  localparam int    LAT   = 17;

  typedef struct {
    int cosv;
    int sinv;
    bit errv;
    int zv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  cordic_sincos_iter_if #(.WIDTH(W)) bus ();

  cordic_sincos_iter #(.WIDTH(W), .FRAC(16), .ITERATIONS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic int rnd_fx(input real r);
    return (r >= 0.0) ? $rtoi(r * 65536.0 + 0.5) : -$rtoi(-r * 65536.0 + 0.5);
  endfunction

  // Reference: true trig of the angle; range limits straight from the angle rules.
  function automatic exp_t model(input int z);
    exp_t e;
    int   lim;
    real  a;
`ifdef CORDIC_QUAD_EN
    lim = rnd_fx(PI_R);
`else
    lim = rnd_fx(PI_R / 2.0);
`endif
    e.zv = z;
    a    = real'(z) / 65536.0;
    if (z > lim || z < -lim) begin
      e.errv = 1'b1;
      e.cosv = 0;
      e.sinv = 0;
    end else begin
      e.errv = 1'b0;
      e.cosv = rnd_fx($cos(a));
      e.sinv = rnd_fx($sin(a));
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req, input int tol);
    int d;
    checks++;
    d = act - req;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, req, tol);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        exp_t e;
        int   tol;
        e   = sbq.pop_front();
        tol = e.errv ? 0 : TOL;
        chk($sformatf("err z=%0d", e.zv), int'(bus.err), int'(e.errv), 0);
        chk($sformatf("cos z=%0d", e.zv), int'(bus.cos_out), e.cosv, tol);
        chk($sformatf("sin z=%0d", e.zv), int'(bus.sin_out), e.sinv, tol);
      end
    end
  end

  task automatic start_op(input int z);
    @(negedge clk);
    bus.enable = 1'b1;
    bus.z_in   = z;
    sbq.push_back(model(z));
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    bus.z_in   = $urandom;
  endtask

  // Called #1 after the accepting edge; counts edges until done and busy samples.
  task automatic wait_done(output int lat, output int bsy);
    lat = 0;
    bsy = bus.busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
      if (bus.busy) bsy++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done after %0d edges, expected done at %0d", lat, LAT);
    end
  endtask

  task automatic op(input int z, input string tag);
    int lat, bsy;
    start_op(z);
    wait_done(lat, bsy);
    chk({"latency ", tag}, lat, LAT, 0);
    chk({"busy_len ", tag}, bsy, LAT, 0);
  endtask

  initial begin
    int lat, bsy, z, r;
    int dir[8] = '{0, 68629, -131072, 205888, 205887, -205888, -68629, 102943};
    bus.enable = 1'b0;
    bus.z_in   = '0;

    // Reset: outputs held at zero while rst is high.
    repeat (2) begin
      @(negedge clk);
      chk("rst busy", int'(bus.busy), 0, 0);
      chk("rst done", int'(bus.done), 0, 0);
      chk("rst err",  int'(bus.err), 0, 0);
      chk("rst cos",  int'(bus.cos_out), 0, 0);
      chk("rst sin",  int'(bus.sin_out), 0, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    foreach (dir[i]) op(dir[i], $sformatf("dir%0d", i));

    r = rnd_fx(PI_R) + 3000;
    for (int i = 0; i < 24; i++) begin
      z = int'($urandom_range(0, 2 * r)) - r;
      op(z, $sformatf("rnd%0d", i));
    end

    // Spurious enable while rotating is ignored; only one done follows.
    start_op(68629);
    repeat (5) @(posedge clk);
    #1;
    bus.enable = 1'b1;
    bus.z_in   = -131072;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    wait_done(lat, bsy);
    chk("midrot latency", lat, LAT - 6, 0);
    repeat (25) @(posedge clk);

    // Back-to-back: enable held through the done cycle.
    @(negedge clk);
    bus.enable = 1'b1;
    bus.z_in   = 40000;
    sbq.push_back(model(40000));
    sbq.push_back(model(-90000));
    @(posedge clk);
    #1;
    bus.z_in = -90000;
    wait_done(lat, bsy);
    chk("b2b first latency", lat, LAT, 0);
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    chk("b2b second accepted", int'(bus.busy), 1, 0);
    wait_done(lat, bsy);
    chk("b2b second latency", lat, LAT, 0);

    // Reset during ROTATE aborts the operation with no done.
    @(negedge clk);
    bus.enable = 1'b1;
    bus.z_in   = 68629;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", int'(bus.busy), 0, 0);
    chk("abort done", int'(bus.done), 0, 0);
    chk("abort err",  int'(bus.err), 0, 0);
    chk("abort cos",  int'(bus.cos_out), 0, 0);
    chk("abort sin",  int'(bus.sin_out), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    chk("scoreboard empty", sbq.size(), 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
